satellite_fuzz_hub: RTL

- Next-generation satellite fuzz controller: arbitrates NUM_SRC fuzzer engines (random, mutated, future engines) onto one Wishbone master port toward the DUT.
- Edge-detects per-engine issue flags and queues timestamped event words in an EVT_DEPTH FIFO.
- Drains the FIFO to the central fuzzer over the ext_master write channel, with timeout and retry.
- Exposes mode, status and counters through the ext_slave register interface.

---
 rtl/satellite_fuzz_hub.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/satellite_fuzz_hub.sv
// satellite_fuzz_hub: routes one selected fuzzer engine onto the DUT Wishbone port,
// turns rising issue flags of that engine into timestamped event words, buffers
// them in a small FIFO and reports them upstream with timeout/retry handling.
module satellite_fuzz_hub #(
  parameter int unsigned           NUM_SRC        = 2,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           EXT_RW_WIDTH   = 32,
  parameter int unsigned           FLAG_W         = 4,
  parameter int unsigned           EVT_DEPTH      = 8,
  parameter int unsigned           MASTER_TIMEOUT = 64,
  parameter int unsigned           MAX_RETRY      = 3,
  parameter logic [ADDR_WIDTH-1:0] REPORT_ADDR    = 32'h80000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ext_slave_we,
  input  logic [ADDR_WIDTH-1:0]             ext_slave_addr_write,
  input  logic [EXT_RW_WIDTH-1:0]           ext_slave_wr_data,
  input  logic [ADDR_WIDTH-1:0]             ext_slave_addr_read,
  output logic [EXT_RW_WIDTH-1:0]           ext_slave_rd_data,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]     src_adr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_dat,
  input  logic [NUM_SRC*(DATA_WIDTH/8)-1:0] src_sel,
  input  logic [NUM_SRC-1:0]                src_we,
  input  logic [NUM_SRC-1:0]                src_stb,
  input  logic [NUM_SRC-1:0]                src_cyc,
  input  logic [NUM_SRC*FLAG_W-1:0]         src_flags,
  output logic [NUM_SRC-1:0]                src_enable,
  output logic [NUM_SRC-1:0]                src_ack,
  output logic [NUM_SRC-1:0]                src_err,
  output logic [DATA_WIDTH-1:0]             src_rdata,
  output logic [ADDR_WIDTH-1:0]             dut_adr,
  output logic [DATA_WIDTH-1:0]             dut_dat,
  output logic [DATA_WIDTH/8-1:0]           dut_sel,
  output logic                              dut_we,
  output logic                              dut_stb,
  output logic                              dut_cyc,
  input  logic                              dut_ack,
  input  logic                              dut_err,
  input  logic [DATA_WIDTH-1:0]             dut_rdata,
  output logic                              ext_master_req,
  output logic                              ext_master_we,
  output logic [ADDR_WIDTH-1:0]             ext_master_addr_write,
  output logic [EXT_RW_WIDTH-1:0]           ext_master_wdata,
  input  logic                              ext_master_write_done,
  output logic                              irq_overflow
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (MASTER_TIMEOUT > 1) ? $clog2(MASTER_TIMEOUT) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RETRY = 2'd2
  } state_t;

  // Mode and source selection
  logic [3:0]         mode_q, mode_d;
  logic [3:0]         pend_q, pend_d;
  logic               act_valid;
  logic [3:0]         act_idx;
  logic [NUM_SRC-1:0] sel_vec;
  logic               act_cyc;
  logic [FLAG_W-1:0]  act_flags;
  logic               mode_change;

  // Event capture
  logic [FLAG_W-1:0]  prev_q, prev_d;
  logic [FLAG_W-1:0]  rose;
  logic               push;
  logic [19:0]        ts_q;
  logic [31:0]        evt_word;

  // FIFO
  logic [31:0]        mem_q [EVT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fifo_full, fifo_empty;
  logic               push_ok, drop;

  // Report FSM
  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               pop_fire;
  logic               fail_inc;

  // Counters and register access
  logic [15:0]        drop_cnt_q;
  logic               irq_q;
  logic [31:0]        total_q;
  logic [15:0]        fail_cnt_q;
  logic               status_clr;
  logic [31:0]        rd32;
  logic               unused_bits;

  assign unused_bits = ^{ext_slave_addr_write[ADDR_WIDTH-1:8],
                         ext_slave_addr_read[ADDR_WIDTH-1:8],
                         ext_slave_wr_data[EXT_RW_WIDTH-1:4]};

  // Decode the active mode into a source index
  always_comb begin
    act_valid = (mode_q != 4'd0) && (32'(mode_q) <= NUM_SRC);
    act_idx   = mode_q - 4'd1;
  end

  // Combinational Wishbone mux from the active engine; zeros when idle
  always_comb begin
    sel_vec   = '0;
    dut_adr   = '0;
    dut_dat   = '0;
    dut_sel   = '0;
    dut_we    = 1'b0;
    dut_stb   = 1'b0;
    dut_cyc   = 1'b0;
    act_cyc   = 1'b0;
    act_flags = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (act_valid && (32'(act_idx) == k)) begin
        sel_vec[k] = 1'b1;
        dut_adr    = src_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
        dut_dat    = src_dat[k*DATA_WIDTH +: DATA_WIDTH];
        dut_sel    = src_sel[k*SEL_W +: SEL_W];
        dut_we     = src_we[k];
        dut_stb    = src_stb[k];
        dut_cyc    = src_cyc[k];
        act_cyc    = src_cyc[k];
        act_flags  = src_flags[k*FLAG_W +: FLAG_W];
      end
    end
  end

  assign src_enable = sel_vec;
  assign src_ack    = sel_vec & {NUM_SRC{dut_ack}};
  assign src_err    = sel_vec & {NUM_SRC{dut_err}};
  assign src_rdata  = dut_rdata;

  // Pending/active mode update; the switch waits for the current bus cycle to end.
  // A MODE write takes effect at the same edge when the switch is allowed.
  always_comb begin
    status_clr = ext_slave_we && (ext_slave_addr_write[7:0] == 8'h04) && ext_slave_wr_data[0];
    pend_d     = pend_q;
    if (ext_slave_we && (ext_slave_addr_write[7:0] == 8'h00)) begin
      pend_d = ext_slave_wr_data[3:0];
    end
    mode_d = mode_q;
    if (!act_valid || !act_cyc) begin
      mode_d = pend_d;
    end
    mode_change = (mode_d != mode_q);
  end

  // Rising-edge detect on the active engine's flags and event word assembly
  always_comb begin
    rose     = act_flags & ~prev_q;
    push     = |rose;
    prev_d   = mode_change ? '0 : act_flags;
    evt_word = {4'hE, act_idx, 4'(rose), ts_q};
  end

  // FIFO bookkeeping; a push at full is still accepted when the head pops
  always_comb begin
    fifo_full  = (cnt_q == CNT_W'(EVT_DEPTH));
    fifo_empty = (cnt_q == '0);
    push_ok    = push && (!fifo_full || pop_fire);
    drop       = push && fifo_full && !pop_fire;
    cnt_d      = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_fire);
  end

  // Report FSM: request, wait for done with timeout, retry, discard
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    pop_fire = 1'b0;
    fail_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        retry_d = '0;
        if (!fifo_empty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ext_master_write_done) begin
          pop_fire = 1'b1;
          state_d  = S_IDLE;
        end else if (timer_q == TMR_W'(MASTER_TIMEOUT - 1)) begin
          timer_d = '0;
          if (retry_q == RTY_W'(MAX_RETRY)) begin
            pop_fire = 1'b1;
            fail_inc = 1'b1;
            state_d  = S_IDLE;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_RETRY;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RETRY: begin
        timer_d = '0;
        state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      drop_cnt_q <= '0;
      irq_q      <= 1'b0;
      total_q    <= '0;
      fail_cnt_q <= '0;
    end else begin
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      prev_q   <= prev_d;
      ts_q     <= ts_q + 20'd1;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && (total_q != 32'hFFFF_FFFF)) begin
        total_q <= total_q + 32'd1;
      end
      if (status_clr) begin
        drop_cnt_q <= '0;
        irq_q      <= 1'b0;
        fail_cnt_q <= '0;
      end else begin
        if (drop) begin
          irq_q <= 1'b1;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end
        end
        if (fail_inc && (fail_cnt_q != 16'hFFFF)) begin
          fail_cnt_q <= fail_cnt_q + 16'd1;
        end
      end
    end
  end

  // Event storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= evt_word;
    end
  end

  assign ext_master_req        = (state_q == S_REQ);
  assign ext_master_we         = 1'b1;
  assign ext_master_addr_write = REPORT_ADDR;
  assign ext_master_wdata      = fifo_empty ? '0 : EXT_RW_WIDTH'(mem_q[rd_ptr_q]);
  assign irq_overflow          = irq_q;

  // Register readback
  always_comb begin
    case (ext_slave_addr_read[7:0])
      8'h00:   rd32 = {28'd0, mode_q};
      8'h04:   rd32 = {drop_cnt_q, 8'(cnt_q), 6'd0, (state_q != S_IDLE), irq_q};
      8'h08:   rd32 = total_q;
      8'h0C:   rd32 = {16'd0, fail_cnt_q};
      default: rd32 = 32'hDEADDEAD;
    endcase
    ext_slave_rd_data = EXT_RW_WIDTH'(rd32);
  end

endmodule
